// File: rtl/vissched_pkg.sv
// vissched_pkg: definitions shared by the vissched sequencer and the sigdelay unit.
//   vis_state_e : sequencer FSM state (idle, running, draining an open accumulation)
//   cnt_width   : register width for a modulo-n counter (at least 1 bit)
//   tbits       : timeslice address width for a given TRATE
package vissched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } vis_state_e;

    // $clog2(1) is 0; a counter that only ever holds 0 still needs a 1-bit register.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned tbits(input int unsigned trate);
        return cnt_width(trate);
    endfunction

endpackage

// File: rtl/vissched_if.sv
// vissched_if: sample stream into the sequencer and framed sig_* stream out of it.
//   in_valid/in_ready/in_dati/in_datq : ready/valid sample input (source -> sequencer)
//   sig_valid/first/next/emit/last    : framing markers for the correlator chain
//   sig_addr                          : timeslice address 0..TRATE-1
//   sig_dati/sig_datq                 : held I / Q sample
// Modport slave is the sequencer side; master is the source/consumer side.
interface vissched_if import vissched_pkg::*; #(
    parameter int unsigned RADIOS = 32,
    parameter int unsigned TBITS  = tbits(30)
) ();

    logic              in_valid;
    logic              in_ready;
    logic [RADIOS-1:0] in_dati;
    logic [RADIOS-1:0] in_datq;

    logic              sig_valid;
    logic              sig_first;
    logic              sig_next;
    logic              sig_emit;
    logic              sig_last;
    logic [TBITS-1:0]  sig_addr;
    logic [RADIOS-1:0] sig_dati;
    logic [RADIOS-1:0] sig_datq;

    modport slave (
        input  in_valid, in_dati, in_datq,
        output in_ready,
        output sig_valid, sig_first, sig_next, sig_emit, sig_last, sig_addr, sig_dati, sig_datq
    );

    modport master (
        output in_valid, in_dati, in_datq,
        input  in_ready,
        input  sig_valid, sig_first, sig_next, sig_emit, sig_last, sig_addr, sig_dati, sig_datq
    );

endinterface

// File: rtl/vissched_modcount.sv
// vissched_modcount: modulo-N up counter.
//   clk_i, rst_ni : clock, asynchronous active-low clear
//   en_i          : advance by one this cycle
//   cnt_o         : current count 0..N-1
//   cnt_next_o    : count after the coming edge
//   wrap_o        : en_i while at N-1 (count returns to 0 at the edge)
module vissched_modcount #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap_o = en_i && (cnt_q == W'(N - 1));
        cnt_d  = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/vissched.sv
// vissched: front-end sequencer for the correlator chain.
// Holds each accepted I/Q sample for TRATE cycles, stepping the timeslice address, and
// frames the stream into LOOP0-sample chunks and LOOP1-chunk accumulations.
//   clock, reset_n : clock, asynchronous active-low reset
//   enable_i       : run integrations while high
//   busy_o         : FSM not idle
//   bus            : sample input handshake and registered sig_* outputs (vissched_if.slave)
module vissched import vissched_pkg::*; #(
    parameter int unsigned RADIOS = 32,
    parameter int unsigned TRATE  = 30,
    parameter int unsigned LOOP0  = 3,
    parameter int unsigned LOOP1  = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable_i,
    output logic       busy_o,
    vissched_if.slave  bus
);

    localparam int unsigned TW = tbits(TRATE);
    localparam int unsigned CW = cnt_width(LOOP0);
    localparam int unsigned AW = cnt_width(LOOP1);

    vis_state_e st_q, st_d;
    logic       held_q, held_d;

    logic [TW-1:0] t_q, t_d;
    logic [CW-1:0] c_q, c_d;
    logic [AW-1:0] a_q, a_d;
    logic          t_wrap, c_wrap, a_wrap;

    logic [RADIOS-1:0] dati_q, dati_d, datq_q, datq_d;

    logic          sig_valid_q, sig_valid_d;
    logic          sig_first_q, sig_first_d;
    logic          sig_next_q, sig_next_d;
    logic          sig_emit_q, sig_emit_d;
    logic          sig_last_q, sig_last_d;
    logic [TW-1:0] sig_addr_q, sig_addr_d;

    logic accept_ok, drain_ok, ready, hs, open_d;

    // t runs only while a sample is held; c steps at each window end, a when c wraps.
    vissched_modcount #(.N(TRATE), .W(TW)) u_cnt_t (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .en_i       (held_q),
        .cnt_o      (t_q),
        .cnt_next_o (t_d),
        .wrap_o     (t_wrap)
    );

    vissched_modcount #(.N(LOOP0), .W(CW)) u_cnt_c (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .en_i       (t_wrap),
        .cnt_o      (c_q),
        .cnt_next_o (c_d),
        .wrap_o     (c_wrap)
    );

    vissched_modcount #(.N(LOOP1), .W(AW)) u_cnt_a (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .en_i       (c_wrap),
        .cnt_o      (a_q),
        .cnt_next_o (a_d),
        .wrap_o     (a_wrap)
    );

    always_comb begin
        // Draining (or RUN with enable low): take a sample only while the accumulation
        // still needs one. a_wrap marks the final cycle of the emit window.
        drain_ok = held_q ? !a_wrap : ((c_q != '0) || (a_q != '0));

        unique case (st_q)
            StIdle:  accept_ok = 1'b0;
            StRun:   accept_ok = enable_i ? 1'b1 : drain_ok;
            StDrain: accept_ok = drain_ok;
            default: accept_ok = 1'b0;
        endcase

        ready  = accept_ok && (!held_q || t_wrap);
        hs     = bus.in_valid && ready;
        held_d = hs || (held_q && !t_wrap);
        open_d = held_d || (c_d != '0) || (a_d != '0);

        st_d = st_q;
        unique case (st_q)
            StIdle:  if (enable_i) st_d = StRun;
            StRun:   if (!enable_i) st_d = open_d ? StDrain : StIdle;
            StDrain: if (!open_d) st_d = StIdle;
            default: st_d = StIdle;
        endcase

        dati_d = hs ? bus.in_dati : dati_q;
        datq_d = hs ? bus.in_datq : datq_q;

        // Outputs are registered copies of the post-edge position.
        sig_valid_d = held_d;
        sig_addr_d  = held_d ? t_d : '0;
        sig_first_d = held_d && (c_d == '0);
        sig_last_d  = held_d && (c_d == CW'(LOOP0 - 1));
        sig_emit_d  = sig_last_d && (a_d == AW'(LOOP1 - 1));
        sig_next_d  = sig_last_d && (a_d != AW'(LOOP1 - 1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= StIdle;
            held_q      <= 1'b0;
            dati_q      <= '0;
            datq_q      <= '0;
            sig_valid_q <= 1'b0;
            sig_first_q <= 1'b0;
            sig_next_q  <= 1'b0;
            sig_emit_q  <= 1'b0;
            sig_last_q  <= 1'b0;
            sig_addr_q  <= '0;
        end else begin
            st_q        <= st_d;
            held_q      <= held_d;
            dati_q      <= dati_d;
            datq_q      <= datq_d;
            sig_valid_q <= sig_valid_d;
            sig_first_q <= sig_first_d;
            sig_next_q  <= sig_next_d;
            sig_emit_q  <= sig_emit_d;
            sig_last_q  <= sig_last_d;
            sig_addr_q  <= sig_addr_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.sig_valid = sig_valid_q;
    assign bus.sig_first = sig_first_q;
    assign bus.sig_next  = sig_next_q;
    assign bus.sig_emit  = sig_emit_q;
    assign bus.sig_last  = sig_last_q;
    assign bus.sig_addr  = sig_addr_q;
    assign bus.sig_dati  = dati_q;
    assign bus.sig_datq  = datq_q;
    assign busy_o        = (st_q != StIdle);

endmodule

// File: tb/tb_vissched.sv
// tb_vissched: drives a TRATE=4 and a TRATE=1 sequencer (LOOP0=3, LOOP1=2, RADIOS=4) with
// the same random stream and compares every output each cycle against a sample-index model.
module tb_vissched;
    import vissched_pkg::*;

    localparam int unsigned L0  = 3;
    localparam int unsigned L1  = 2;
    localparam int unsigned NS  = L0 * L1;
    localparam int unsigned RAD = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic enable  = 1'b0;
    logic busy4, busy1;

    logic           vld;
    logic [RAD-1:0] di, dq;

    vissched_if #(.RADIOS(RAD), .TBITS(tbits(4))) bus4 ();
    vissched_if #(.RADIOS(RAD), .TBITS(tbits(1))) bus1 ();

    vissched #(.RADIOS(RAD), .TRATE(4), .LOOP0(L0), .LOOP1(L1)) u_dut4 (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable_i (enable),
        .busy_o   (busy4),
        .bus      (bus4.slave)
    );

    vissched #(.RADIOS(RAD), .TRATE(1), .LOOP0(L0), .LOOP1(L1)) u_dut1 (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable_i (enable),
        .busy_o   (busy1),
        .bus      (bus1.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0 idle / 1 run / 2 drain; n is the sample's index inside the
    // accumulation (chunk index n%L0, chunk number n/L0); w is the cycle within its window.
    int             m_mode[2];
    bit             m_held[2];
    int             m_w[2];
    int             m_n[2];
    logic [RAD-1:0] m_di[2];
    logic [RAD-1:0] m_dq[2];

    function automatic int trate_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic bit model_ready(input int d);
        bit wend, take, more, allow;
        wend  = m_held[d] && (m_w[d] == trate_of(d) - 1);
        take  = !m_held[d] || wend;
        more  = m_held[d] ? (m_n[d] != NS - 1) : (m_n[d] != 0);
        allow = (m_mode[d] == 1 && enable) || (m_mode[d] != 0 && more);
        return allow && take;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0;
            m_held[d] = 1'b0;
            m_w[d]    = 0;
            m_n[d]    = 0;
            m_di[d]   = '0;
            m_dq[d]   = '0;
        end
    endtask

    task automatic model_step(input int d);
        bit hs, open;
        hs = vld && model_ready(d);
        if (m_held[d]) begin
            if (m_w[d] == trate_of(d) - 1) begin
                m_n[d]    = (m_n[d] + 1) % NS;
                m_held[d] = hs;
                m_w[d]    = 0;
            end else begin
                m_w[d]++;
            end
        end else if (hs) begin
            m_held[d] = 1'b1;
        end
        if (hs) begin
            m_di[d] = di;
            m_dq[d] = dq;
        end
        open = m_held[d] || (m_n[d] != 0);
        case (m_mode[d])
            0: if (enable) m_mode[d] = 1;
            1: if (!enable) m_mode[d] = open ? 2 : 0;
            default: if (!open) m_mode[d] = 0;
        endcase
    endtask

    task automatic compare_dut(input int d);
        bit held, last, emit;
        held = m_held[d];
        last = held && (m_n[d] % L0 == L0 - 1);
        emit = last && (m_n[d] / L0 == L1 - 1);
        check_eq($sformatf("d%0d in_ready", d), 64'(d == 0 ? bus4.in_ready : bus1.in_ready),
                 64'(model_ready(d)));
        check_eq($sformatf("d%0d busy", d), 64'(d == 0 ? busy4 : busy1), 64'(m_mode[d] != 0));
        check_eq($sformatf("d%0d sig_valid", d), 64'(d == 0 ? bus4.sig_valid : bus1.sig_valid),
                 64'(held));
        check_eq($sformatf("d%0d sig_addr", d),
                 (d == 0) ? 64'(bus4.sig_addr) : 64'(bus1.sig_addr),
                 held ? 64'(m_w[d]) : 64'd0);
        check_eq($sformatf("d%0d sig_first", d), 64'(d == 0 ? bus4.sig_first : bus1.sig_first),
                 64'(held && (m_n[d] % L0 == 0)));
        check_eq($sformatf("d%0d sig_last", d), 64'(d == 0 ? bus4.sig_last : bus1.sig_last),
                 64'(last));
        check_eq($sformatf("d%0d sig_next", d), 64'(d == 0 ? bus4.sig_next : bus1.sig_next),
                 64'(last && !emit));
        check_eq($sformatf("d%0d sig_emit", d), 64'(d == 0 ? bus4.sig_emit : bus1.sig_emit),
                 64'(emit));
        check_eq($sformatf("d%0d sig_dati", d),
                 (d == 0) ? 64'(bus4.sig_dati) : 64'(bus1.sig_dati), 64'(m_di[d]));
        check_eq($sformatf("d%0d sig_datq", d),
                 (d == 0) ? 64'(bus4.sig_datq) : 64'(bus1.sig_datq), 64'(m_dq[d]));
    endtask

    task automatic apply_inputs();
        bus4.in_valid = vld;
        bus4.in_dati  = di;
        bus4.in_datq  = dq;
        bus1.in_valid = vld;
        bus1.in_dati  = di;
        bus1.in_datq  = dq;
    endtask

    // pv: percent of cycles with valid; ptog: per-mille chance per cycle of toggling enable.
    task automatic run(input int cycles, input int pv, input int ptog);
        repeat (cycles) begin
            @(negedge clock);
            compare_dut(0);
            compare_dut(1);
            @(posedge clock);
            model_step(0);
            model_step(1);
            #1;
            vld = ($urandom_range(99) < pv);
            di  = RAD'($urandom);
            dq  = RAD'($urandom);
            if ($urandom_range(999) < ptog) enable = ~enable;
            apply_inputs();
        end
    endtask

    // Reset asserted mid-cycle; outputs must drop before any clock edge.
    task automatic mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_dut(0);
        compare_dut(1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
    endtask

    initial begin
        vld = 1'b0;
        di  = '0;
        dq  = '0;
        apply_inputs();
        model_reset();
        #1;
        reset_n = 1'b0;
        #1;
        compare_dut(0);
        compare_dut(1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        enable = 1'b1;
        vld    = 1'b1;
        apply_inputs();
        run(80, 100, 0);   // continuous stream, back-to-back windows
        run(10, 0, 0);     // source gap
        run(300, 50, 0);   // random gaps
        enable = 1'b0;
        run(60, 100, 0);   // drain then idle
        enable = 1'b1;
        run(1500, 80, 25); // enable toggling, incl. re-assertion during drain
        for (int r = 0; r < 4; r++) begin
            run(50 + int'($urandom_range(150)), 85, 20);
            mid_reset();
        end
        run(400, 70, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vissched.md
# vissched

Front-end sequencer for the correlator chain. Accepts one RADIOS-wide I/Q sample per ready/valid handshake and holds each sample for TRATE cycles, driving the timeslice address. It generates the valid/first/next/emit/last framing that partitions the stream into LOOP0-sample partial sums and LOOP1-partial-sum accumulations. Sits between the radio-sample source and the correlator chain's sig_* inputs, and owns start/stop of integration.

## Interface
- RADIOS, 32, number of 1-bit I/Q sources
- TRATE, 30, cycles per sample (time-multiplex rate); TBITS = $clog2(TRATE)
- LOOP0, 3, samples per partial sum (chunk)
- LOOP1, 5, chunks per accumulation
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- enable_i  in  1  level: run integrations while high
- in_valid_i  in  1  source sample valid
- in_ready_o  out  1  block accepts sample this cycle
- in_dati_i / in_datq_i  in  RADIOS  I / Q sample bits
- sig_valid_o  out  1  held sample present
- sig_first_o  out  1  sample is chunk index 0
- sig_next_o  out  1  last sample of a non-final chunk
- sig_emit_o  out  1  last sample of the final chunk of an accumulation
- sig_last_o  out  1  sample is chunk index LOOP0-1
- sig_addr_o  out  TBITS  timeslice 0..TRATE-1
- sig_dati_o / sig_datq_o  out  RADIOS  held I / Q sample
- busy_o  out  1  state != IDLE

## Operation
- Counters: t (0..TRATE-1), c (0..LOOP0-1), a (0..LOOP1-1); cascaded. t wraps each held-sample window; c advances at window end; a advances when c wraps.
- Holding register: loaded on handshake (in_valid_i & in_ready_o).
- in_ready_o = (state==RUN or DRAIN-with-accumulation-open) & (!held | t==TRATE-1).
- All sig_* outputs registered. While held: sig_valid_o=1, sig_addr_o=t, first=(c==0), last=(c==LOOP0-1), next=last&(a!=LOOP1-1), emit=last&(a==LOOP1-1). Markers are constant across the whole TRATE window of a sample.
- Not held: sig_valid_o and all markers 0, sig_addr_o=0; data outputs keep their last value.
- Stall (no sample at window end): held clears, t→0, c/a hold; framing resumes with the next sample.
- FSM:
  - IDLE → RUN on enable_i.
  - RUN → DRAIN when enable_i falls and accumulation open ((c,a)!=(0,0) or held).
  - RUN → IDLE when enable_i falls at a boundary ((c,a)==(0,0), !held).
  - DRAIN keeps accepting until the emit window's final cycle (t==TRATE-1) completes, then IDLE; no new sample is accepted at that cycle.
  - DRAIN ignores re-assertion of enable_i until IDLE is reached.
- IDLE: in_ready_o=0; counters at 0.

## Timing
- Reset value: every output 0; state IDLE; counters 0; holding register cleared.
- Latency: sample accepted at edge k → sig_valid_o=1, sig_addr_o=0 from cycle k+1 through k+TRATE.
- Back-to-back: accept during t==TRATE-1 cycle → no bubble; next window starts at addr 0 the following cycle.
- Simultaneous enable_i fall and emit-window end: go directly to IDLE.
- TRATE==1: each sample lasts one cycle; ready stays high while running.
- Reset mid-window: outputs drop asynchronously; partial accumulation discarded.

## Structure
- Shared package: FSM state enum (IDLE, RUN, DRAIN) and the TBITS / counter-width helper functions, shared with the sigdelay unit.
- One sub-module, vissched_modcount: modulo-N counter with enable, wrap output and async active-low clear, instantiated three times (t, c, a).

## Test plan
- TRATE=4, LOOP0=3, LOOP1=2, RADIOS=4; continuous valid, enable high: 6 samples produce 24 valid cycles; addr 0,1,2,3 repeating; first on samples 0,3; next on sample 2; emit on sample 5; no bubbles.
- Source gap of 5 cycles after sample 1: valid low for 5+ cycles, addr=0; sample 2 still flagged last/next.
- enable_i dropped during sample 1: DRAIN; samples through emit on sample 5 are accepted; then busy_o=0 and in_ready_o=0; enable_i re-asserted during DRAIN is ignored.
- enable_i dropped at a boundary with nothing held: IDLE next cycle, in_ready_o=0.
- reset_n asserted at t=2 of sample 3: all outputs 0 immediately. After release and enable, the next sample is flagged first with a=0.
- TRATE=1: 6 consecutive samples yield first/last/next/emit pattern on consecutive cycles, addr stuck at 0.
